// File: rtl/shape_sequencer_pkg.sv
// Shared types and constants for the draw-command sequencer: shape codes,
// splitter output_sel codes and the per-shape segment table lookups.
package shape_sequencer_pkg;

   localparam int OPW  = 76;
   localparam int LOCW = 38;
   localparam int POSW = 19;

   typedef enum logic [1:0] {
      LINE   = 2'b00,
      TRI    = 2'b01,
      CIRCLE = 2'b10,
      RSVD   = 2'b11
   } shape_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2
   } state_t;

   localparam logic [3:0] LL1      = 4'd0;
   localparam logic [3:0] TL1      = 4'd1;
   localparam logic [3:0] TL2      = 4'd2;
   localparam logic [3:0] TL3      = 4'd3;
   localparam logic [3:0] CA1      = 4'd4;
   localparam logic [3:0] SEL_NONE = 4'hF;

   // Index of the final segment for a shape; triangles walk three edges.
   function automatic logic [1:0] lastIdx(input shape_t shape);
      logic [1:0] last;
      last = 2'd0;
      if (shape == TRI) last = 2'd2;
      return last;
   endfunction

   function automatic logic [3:0] segSel(input shape_t shape, input logic [1:0] idx);
      logic [3:0] sel;
      sel = SEL_NONE;
      case (shape)
         LINE:   sel = LL1;
         TRI: begin
            case (idx)
               2'd0:    sel = TL1;
               2'd1:    sel = TL2;
               2'd2:    sel = TL3;
               default: sel = SEL_NONE;
            endcase
         end
         CIRCLE: sel = CA1;
         default: sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/shape_sequencer_if.sv
// Bundle of the command, splitter and segment handshakes around the sequencer.
// master is the sequencer's view, slave is the surrounding GPU's view.
interface shape_sequencer_if;
   import shape_sequencer_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   shape_t            cmd_shape;
   logic [OPW-1:0]    cmd_opdata;
   logic              abort;

   logic [OPW-1:0]    sp_opdata;
   logic [3:0]        sp_sel;
   logic [LOCW-1:0]   sp_locations;

   logic              seg_valid;
   logic              seg_ready;
   logic [LOCW-1:0]   seg_loc;
   logic              seg_circle;
   logic              seg_last;
   logic              done;
   logic              err;

   modport master (
      input  cmd_valid, cmd_shape, cmd_opdata, abort, sp_locations, seg_ready,
      output cmd_ready, sp_opdata, sp_sel, seg_valid, seg_loc, seg_circle, seg_last, done, err
   );

   modport slave (
      output cmd_valid, cmd_shape, cmd_opdata, abort, sp_locations, seg_ready,
      input  cmd_ready, sp_opdata, sp_sel, seg_valid, seg_loc, seg_circle, seg_last, done, err
   );

endinterface

// File: rtl/shape_sequencer.sv
// Walks the splitter through each shape's segment list and hands every
// captured {start,end} or {centre,radius} pair to the rasterizer.
module shape_sequencer
   import shape_sequencer_pkg::*;
(
   input logic               clk,
   input logic               rst,
   shape_sequencer_if.master bus
);

   state_t            state_q,      state_d;
   shape_t            shape_q,      shape_d;
   logic [1:0]        idx_q,        idx_d;
   logic [OPW-1:0]    sp_opdata_q,  sp_opdata_d;
   logic [LOCW-1:0]   seg_loc_q,    seg_loc_d;
   logic              seg_circle_q, seg_circle_d;
   logic              seg_last_q,   seg_last_d;
   logic              done_q,       done_d;
   logic              err_q,        err_d;

   logic              cmdReady;
   logic              segValid;
   logic [3:0]        spSel;

   // State and output registers; reset discards any in-flight segment.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shape_q      <= LINE;
         idx_q        <= 2'd0;
         sp_opdata_q  <= '0;
         seg_loc_q    <= '0;
         seg_circle_q <= 1'b0;
         seg_last_q   <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         shape_q      <= shape_d;
         idx_q        <= idx_d;
         sp_opdata_q  <= sp_opdata_d;
         seg_loc_q    <= seg_loc_d;
         seg_circle_q <= seg_circle_d;
         seg_last_q   <= seg_last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Next-state logic: abort dominates everything, including a same-cycle accept.
   always_comb begin
      state_d      = state_q;
      shape_d      = shape_q;
      idx_d        = idx_q;
      sp_opdata_d  = sp_opdata_q;
      seg_loc_d    = seg_loc_q;
      seg_circle_d = seg_circle_q;
      seg_last_d   = seg_last_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cmdReady     = 1'b0;
      segValid     = 1'b0;
      spSel        = SEL_NONE;

      case (state_q)
         S_IDLE: begin
            cmdReady = !bus.abort;
            if (bus.cmd_valid && !bus.abort) begin
               sp_opdata_d = bus.cmd_opdata;
               shape_d     = bus.cmd_shape;
               idx_d       = 2'd0;
               if (bus.cmd_shape == RSVD) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            spSel = segSel(shape_q, idx_q);
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               seg_loc_d    = bus.sp_locations;
               seg_circle_d = (shape_q == CIRCLE);
               seg_last_d   = (idx_q == lastIdx(shape_q));
               state_d      = S_SEND;
            end
         end

         S_SEND: begin
            segValid = 1'b1;
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.seg_ready) begin
               if (seg_last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_LOAD;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready  = cmdReady;
   assign bus.sp_opdata  = sp_opdata_q;
   assign bus.sp_sel     = spSel;
   assign bus.seg_valid  = segValid;
   assign bus.seg_loc    = seg_loc_q;
   assign bus.seg_circle = seg_circle_q;
   assign bus.seg_last   = seg_last_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_shape_sequencer.sv
// Bench for shape_sequencer: models the location splitter and predicts each
// command's segment list from the shape's edge rules.
module tb_shape_sequencer;
   import shape_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   shape_sequencer_if bus();

   shape_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Splitter stand-in: picks the point pair named by output_sel.
   logic [18:0] spP1, spP2, spP3;
   assign spP1 = bus.sp_opdata[75:57];
   assign spP2 = bus.sp_opdata[56:38];
   assign spP3 = bus.sp_opdata[37:19];

   always_comb begin
      bus.sp_locations = '0;
      case (bus.sp_sel)
         LL1, TL1: bus.sp_locations = {spP1, spP2};
         TL2:      bus.sp_locations = {spP2, spP3};
         TL3, CA1: bus.sp_locations = {spP1, spP3};
         default:  bus.sp_locations = '0;
      endcase
   end

   int          cyc = 0;
   logic [37:0] gotLoc[$];
   logic        gotCirc[$];
   logic        gotLast[$];
   int          gotCyc[$];
   logic [3:0]  gotSel[$];
   int          doneCnt, doneCyc, errCnt, errCyc, validCnt;

   logic [37:0] expLoc[$];
   logic        expCirc[$];
   logic        expLast[$];
   logic [3:0]  expSel[$];

   // Passive log of everything the DUT presents, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (bus.sp_sel !== SEL_NONE) gotSel.push_back(bus.sp_sel);
      if (bus.seg_valid === 1'b1) validCnt++;
      if (bus.seg_valid === 1'b1 && bus.seg_ready === 1'b1 && bus.abort !== 1'b1 && rst !== 1'b1) begin
         gotLoc.push_back(bus.seg_loc);
         gotCirc.push_back(bus.seg_circle);
         gotLast.push_back(bus.seg_last);
         gotCyc.push_back(cyc);
      end
      if (bus.done === 1'b1) begin doneCnt++; doneCyc = cyc; end
      if (bus.err === 1'b1) begin errCnt++; errCyc = cyc; end
   end

   function automatic logic [18:0] pt(input logic [9:0] x, input logic [8:0] y);
      return {x, y};
   endfunction

   function automatic logic [75:0] mkOp(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c);
      return {a, b, c, 19'h5A5A5};
   endfunction

   task automatic clearLog();
      gotLoc.delete(); gotCirc.delete(); gotLast.delete(); gotCyc.delete(); gotSel.delete();
      expLoc.delete(); expCirc.delete(); expLast.delete(); expSel.delete();
      doneCnt = 0; doneCyc = -1; errCnt = 0; errCyc = -1; validCnt = 0;
   endtask

   // Reference: a line is one edge, a triangle its three edges A-B, B-C, A-C,
   // a circle one {centre,radius} pair; reserved codes draw nothing.
   task automatic buildExpected(input logic [1:0] shape, input logic [75:0] op);
      logic [18:0] a, b, c;
      a = op[75:57]; b = op[56:38]; c = op[37:19];
      if (shape == 2'b00) begin
         expLoc.push_back({a, b}); expCirc.push_back(1'b0); expLast.push_back(1'b1); expSel.push_back(4'd0);
      end else if (shape == 2'b01) begin
         expLoc.push_back({a, b}); expCirc.push_back(1'b0); expLast.push_back(1'b0); expSel.push_back(4'd1);
         expLoc.push_back({b, c}); expCirc.push_back(1'b0); expLast.push_back(1'b0); expSel.push_back(4'd2);
         expLoc.push_back({a, c}); expCirc.push_back(1'b0); expLast.push_back(1'b1); expSel.push_back(4'd3);
      end else if (shape == 2'b10) begin
         expLoc.push_back({a, c}); expCirc.push_back(1'b1); expLast.push_back(1'b1); expSel.push_back(4'd4);
      end
   endtask

   task automatic sendCmd(input logic [1:0] shape, input logic [75:0] op, output int acc);
      @(posedge clk); #1;
      bus.cmd_valid  = 1'b1;
      bus.cmd_shape  = shape_t'(shape);
      bus.cmd_opdata = op;
      @(posedge clk);
      acc = cyc;
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
      total++; if (bus.seg_valid !== 1'b0) begin bad++; $display("FAIL reset_seg_valid got=%b exp=0", bus.seg_valid); end
      total++; if ({bus.seg_circle, bus.seg_last, bus.done, bus.err} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.seg_circle, bus.seg_last, bus.done, bus.err}); end
      total++; if (bus.seg_loc !== 38'd0) begin bad++; $display("FAIL reset_seg_loc got=%h exp=0", bus.seg_loc); end
      total++; if (bus.sp_opdata !== 76'd0) begin bad++; $display("FAIL reset_sp_opdata got=%h exp=0", bus.sp_opdata); end
      total++; if (bus.sp_sel !== 4'hF) begin bad++; $display("FAIL reset_sp_sel got=%h exp=f", bus.sp_sel); end
      rst = 1'b0;
   endtask

   task automatic test_line();
      int acc;
      clearLog();
      bus.seg_ready = 1'b1;
      sendCmd(2'b00, mkOp(pt(10'd10, 9'd20), pt(10'd100, 9'd200), 19'd0), acc);
      repeat (6) @(posedge clk);
      total++; if (gotLoc.size() != 1) begin bad++; $display("FAIL line_count got=%0d exp=1", gotLoc.size()); end
      else begin
         total++; if (gotLoc[0] !== {10'd10, 9'd20, 10'd100, 9'd200}) begin bad++; $display("FAIL line_loc got=%h exp=%h", gotLoc[0], {10'd10, 9'd20, 10'd100, 9'd200}); end
         total++; if ({gotCirc[0], gotLast[0]} !== 2'b01) begin bad++; $display("FAIL line_flags got=%b exp=01", {gotCirc[0], gotLast[0]}); end
         total++; if (gotCyc[0] != acc + 2) begin bad++; $display("FAIL line_latency got=%0d exp=%0d", gotCyc[0] - acc, 2); end
      end
      total++; if (doneCnt != 1 || doneCyc != acc + 3) begin bad++; $display("FAIL line_done got=%0d@%0d exp=1@%0d", doneCnt, doneCyc - acc, 3); end
      total++; if (gotSel.size() != 1 || gotSel[0] !== 4'd0) begin bad++; $display("FAIL line_sel got_n=%0d exp sel 0", gotSel.size()); end
   endtask

   task automatic test_tri();
      int acc;
      logic [37:0] want[3];
      want[0] = {pt(10'd0, 9'd0), pt(10'd50, 9'd0)};
      want[1] = {pt(10'd50, 9'd0), pt(10'd0, 9'd40)};
      want[2] = {pt(10'd0, 9'd0), pt(10'd0, 9'd40)};
      clearLog();
      bus.seg_ready = 1'b1;
      sendCmd(2'b01, mkOp(pt(10'd0, 9'd0), pt(10'd50, 9'd0), pt(10'd0, 9'd40)), acc);
      repeat (10) @(posedge clk);
      total++; if (gotLoc.size() != 3) begin bad++; $display("FAIL tri_count got=%0d exp=3", gotLoc.size()); end
      else begin
         for (int k = 0; k < 3; k++) begin
            total++; if (gotLoc[k] !== want[k]) begin bad++; $display("FAIL tri_loc%0d got=%h exp=%h", k, gotLoc[k], want[k]); end
            total++; if (gotLast[k] !== (k == 2) || gotCirc[k] !== 1'b0) begin bad++; $display("FAIL tri_flags%0d got=%b%b exp=0%b", k, gotCirc[k], gotLast[k], k == 2); end
            total++; if (gotCyc[k] != acc + 2 + 2 * k) begin bad++; $display("FAIL tri_timing%0d got=%0d exp=%0d", k, gotCyc[k] - acc, 2 + 2 * k); end
         end
      end
      total++; if (gotSel.size() != 3 || gotSel[0] !== 4'd1 || gotSel[1] !== 4'd2 || gotSel[2] !== 4'd3) begin bad++; $display("FAIL tri_sel got_n=%0d exp 1,2,3", gotSel.size()); end
      total++; if (doneCnt != 1 || doneCyc != acc + 7) begin bad++; $display("FAIL tri_done got=%0d@%0d exp=1@7", doneCnt, doneCyc - acc); end
   endtask

   task automatic test_circle();
      int acc;
      logic [37:0] want;
      want = {pt(10'd320, 9'd240), pt(10'd0, 9'd30)};
      clearLog();
      bus.seg_ready = 1'b1;
      sendCmd(2'b10, mkOp(pt(10'd320, 9'd240), 19'h12345, pt(10'd0, 9'd30)), acc);
      repeat (6) @(posedge clk);
      total++; if (gotLoc.size() != 1) begin bad++; $display("FAIL circle_count got=%0d exp=1", gotLoc.size()); end
      else begin
         total++; if (gotLoc[0] !== want) begin bad++; $display("FAIL circle_loc got=%h exp=%h", gotLoc[0], want); end
         total++; if ({gotCirc[0], gotLast[0]} !== 2'b11) begin bad++; $display("FAIL circle_flags got=%b exp=11", {gotCirc[0], gotLast[0]}); end
      end
      total++; if (gotSel.size() != 1 || gotSel[0] !== 4'd4) begin bad++; $display("FAIL circle_sel got_n=%0d exp sel 4", gotSel.size()); end
      total++; if (doneCnt != 1) begin bad++; $display("FAIL circle_done got=%0d exp=1", doneCnt); end
   endtask

   task automatic test_backpressure();
      int acc;
      logic [75:0] op;
      logic [37:0] held;
      op = mkOp(pt(10'd700, 9'd300), pt(10'd5, 9'd511), 19'd0);
      clearLog();
      buildExpected(2'b00, op);
      bus.seg_ready = 1'b0;
      sendCmd(2'b00, op, acc);
      for (int i = 0; i < 10 && bus.seg_valid !== 1'b1; i++) @(negedge clk);
      total++; if (bus.seg_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got=%b exp=1", bus.seg_valid); end
      held = bus.seg_loc;
      total++; if (held !== expLoc[0]) begin bad++; $display("FAIL bp_loc got=%h exp=%h", held, expLoc[0]); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (bus.seg_valid !== 1'b1 || bus.seg_loc !== expLoc[0] || bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold%0d got valid=%b loc=%h rdy=%b exp valid=1 loc=%h rdy=0", i, bus.seg_valid, bus.seg_loc, bus.cmd_ready, expLoc[0]);
         end
      end
      @(posedge clk); #1 bus.seg_ready = 1'b1;
      repeat (4) @(posedge clk);
      total++; if (doneCnt != 1 || gotLoc.size() != 1) begin bad++; $display("FAIL bp_release got done=%0d segs=%0d exp 1,1", doneCnt, gotLoc.size()); end
   endtask

   task automatic test_reserved();
      int acc;
      logic [75:0] op;
      op = {12'hABC, 32'($urandom), 32'($urandom)};
      clearLog();
      bus.seg_ready = 1'b1;
      sendCmd(2'b11, op, acc);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if (bus.cmd_ready !== 1'b1 || bus.seg_valid !== 1'b0) begin bad++; $display("FAIL rsvd_idle%0d got rdy=%b valid=%b exp 1,0", i, bus.cmd_ready, bus.seg_valid); end
      end
      total++; if (errCnt != 1 || errCyc != acc + 1) begin bad++; $display("FAIL rsvd_err got=%0d@%0d exp=1@1", errCnt, errCyc - acc); end
      total++; if (validCnt != 0 || gotSel.size() != 0 || doneCnt != 0) begin bad++; $display("FAIL rsvd_quiet got valid=%0d sel=%0d done=%0d exp 0", validCnt, gotSel.size(), doneCnt); end
      total++; if (bus.sp_opdata !== op) begin bad++; $display("FAIL rsvd_opdata got=%h exp=%h", bus.sp_opdata, op); end
   endtask

   task automatic test_abort_reset();
      int acc;
      logic [75:0] op;
      clearLog();
      bus.seg_ready = 1'b0;
      sendCmd(2'b01, mkOp(pt(10'd1, 9'd2), pt(10'd3, 9'd4), pt(10'd5, 9'd6)), acc);
      for (int i = 0; i < 10 && bus.seg_valid !== 1'b1; i++) @(negedge clk);
      @(posedge clk); #1 bus.seg_ready = 1'b1;
      @(posedge clk); #1 bus.seg_ready = 1'b0;
      for (int i = 0; i < 10 && bus.seg_valid !== 1'b1; i++) @(negedge clk);
      total++; if (bus.seg_valid !== 1'b1) begin bad++; $display("FAIL abort_second_seg_timeout got=%b exp=1", bus.seg_valid); end
      #1; bus.abort = 1'b1; bus.seg_ready = 1'b1;
      @(posedge clk); #1; bus.abort = 1'b0; bus.seg_ready = 1'b0;
      @(negedge clk);
      total++; if (bus.seg_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got valid=%b rdy=%b exp 0,1", bus.seg_valid, bus.cmd_ready); end
      repeat (4) @(posedge clk);
      total++; if (doneCnt != 0 || gotLoc.size() != 1) begin bad++; $display("FAIL abort_no_done got done=%0d segs=%0d exp 0,1", doneCnt, gotLoc.size()); end
      clearLog();
      sendCmd(2'b00, mkOp(pt(10'd9, 9'd9), pt(10'd8, 9'd8), 19'd0), acc);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.sp_sel !== 4'hF || bus.seg_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got sel=%h valid=%b rdy=%b exp f,0,1", bus.sp_sel, bus.seg_valid, bus.cmd_ready); end
      total++; if (bus.sp_opdata !== 76'd0 || bus.seg_loc !== 38'd0) begin bad++; $display("FAIL rst_mid_regs got op=%h loc=%h exp 0,0", bus.sp_opdata, bus.seg_loc); end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      total++; if (doneCnt != 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", doneCnt); end
      clearLog();
      op = mkOp(pt(10'd33, 9'd44), pt(10'd55, 9'd66), 19'd0);
      buildExpected(2'b00, op);
      bus.seg_ready = 1'b1;
      sendCmd(2'b00, op, acc);
      repeat (6) @(posedge clk);
      total++; if (gotLoc.size() != 1 || gotLoc[0] !== expLoc[0] || doneCnt != 1) begin bad++; $display("FAIL rst_next_cmd got segs=%0d done=%0d exp 1,1", gotLoc.size(), doneCnt); end
   endtask

   task automatic test_random();
      int acc;
      logic [1:0]  shape;
      logic [95:0] raw;
      for (int n = 0; n < 40; n++) begin
         shape = 2'($urandom_range(0, 3));
         raw = {$urandom, $urandom, $urandom};
         clearLog();
         buildExpected(shape, raw[75:0]);
         bus.seg_ready = 1'($urandom_range(0, 1));
         sendCmd(shape, raw[75:0], acc);
         for (int c = 0; c < 80 && (doneCnt + errCnt) == 0; c++) begin
            @(posedge clk); #1 bus.seg_ready = 1'($urandom_range(0, 1));
         end
         repeat (2) @(posedge clk);
         total++; if ((doneCnt + errCnt) == 0) begin bad++; $display("FAIL rand%0d_timeout got no done/err shape=%0d", n, shape); end
         total++; if (gotLoc.size() != expLoc.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, gotLoc.size(), expLoc.size()); end
         else begin
            for (int k = 0; k < expLoc.size(); k++) begin
               total++; if (gotLoc[k] !== expLoc[k] || gotCirc[k] !== expCirc[k] || gotLast[k] !== expLast[k]) begin
                  bad++; $display("FAIL rand%0d_seg%0d got=%h/%b%b exp=%h/%b%b", n, k, gotLoc[k], gotCirc[k], gotLast[k], expLoc[k], expCirc[k], expLast[k]);
               end
            end
         end
         total++; if (gotSel != expSel) begin bad++; $display("FAIL rand%0d_sel got_n=%0d exp_n=%0d", n, gotSel.size(), expSel.size()); end
         total++; if (doneCnt != (shape == 2'b11 ? 0 : 1) || errCnt != (shape == 2'b11 ? 1 : 0)) begin
            bad++; $display("FAIL rand%0d_pulses got done=%0d err=%0d shape=%0d", n, doneCnt, errCnt, shape);
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_shape  = LINE;
      bus.cmd_opdata = '0;
      bus.abort      = 1'b0;
      bus.seg_ready  = 1'b0;
      clearLog();
      test_reset();
      test_line();
      test_tri();
      test_circle();
      test_backpressure();
      test_reserved();
      test_abort_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
